// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the sequential divider: funct3[1:0] operation
// encodings, the controller state enum, the iteration count, and small
// decode helpers used by the top level.
// -----------------------------------------------------------------------------
package div_seq_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration: shift the partial
// remainder left bringing in the next dividend bit, trial-subtract the
// divisor, and keep the difference when it does not borrow.
//
// Ports
//   rem_i      partial remainder before this iteration
//   msb_i      next dividend bit (MSB first)
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after this iteration
//   q_bit_o    quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;
    logic            unused_trial_bit;

    always_comb begin
        rem_sh  = {rem_i, msb_i};
        // Extra top bit acts as the borrow flag of the trial subtraction.
        trial   = {1'b0, rem_sh} - {2'b00, divisor_i};
        q_bit_o = ~trial[XLEN+1];
        // Whichever value is kept is always below the divisor, so it fits XLEN.
        rem_o   = q_bit_o ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    end

    assign unused_trial_bit = trial[XLEN];

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Sequential 32-iteration restoring divider for DIV/DIVU/REM/REMU with a
// valid/ready request side and a valid/ready result side.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   request handshake; rs1, rs2, funct3 captured on accept
//   funct3[1:0]         00 DIV, 01 DIVU, 10 REM, 11 REMU (bit 2 ignored)
//   rs1, rs2            dividend, divisor
//   flush               abort any operation; forces IDLE on the next edge
//   out_valid/out_ready result handshake
//   result              quotient or remainder, stable while out_valid=1
//   busy                controller not in IDLE
//
// Build option
//   DIV_FAST_SPECIAL_EN  divide-by-zero and signed overflow jump straight
//                        from IDLE to DONE on accept instead of iterating.
//
// state | meaning
// IDLE  | waiting for a request
// PREP  | form operand magnitudes, record result signs, load counter
// CALC  | one restoring iteration per cycle, counter 31 down to 0
// FIX   | sign-correct, pick quotient/remainder, substitute special cases
// DONE  | result presented until out_ready
// -----------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;

    op_e             in_op;
    logic            accept;
    logic            fast_hit;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic            unused_funct3;

    // Divide-by-zero or signed overflow: both have fixed architectural results.
    function automatic logic is_special(input op_e op, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        return (b == '0) || (op_is_signed(op) && (a == MIN_NEG) && (b == '1));
    endfunction

    function automatic logic [XLEN-1:0] special_value(input op_e op,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
        if (b == '0) return op_is_rem(op) ? a : '1;
        else         return op_is_rem(op) ? '0 : a;
    endfunction

    assign in_op         = op_e'(funct3[1:0]);
    assign unused_funct3 = funct3[2];
    assign in_ready      = (state_q == S_IDLE) && !flush;
    assign accept        = in_valid && in_ready;
    assign out_valid     = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign result        = result_q;

`ifdef DIV_FAST_SPECIAL_EN
    assign fast_hit = is_special(in_op, rs1, rs2);
`else
    assign fast_hit = 1'b0;
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .msb_i     (quo_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_d = in_op;
                        a_d  = rs1;
                        b_d  = rs2;
                        if (fast_hit) begin
                            result_d = special_value(in_op, rs1, rs2);
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    quo_d   = (op_is_signed(op_q) && a_q[XLEN-1]) ? -a_q : a_q;
                    dvs_d   = (op_is_signed(op_q) && b_q[XLEN-1]) ? -b_q : b_q;
                    rem_d   = '0;
                    q_neg_d = op_is_signed(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    r_neg_d = op_is_signed(op_q) && a_q[XLEN-1];
                    cnt_d   = 5'(ITER - 1);
                    state_d = S_CALC;
                end
                S_CALC: begin
                    // quo_q doubles as the dividend shift register: its MSB feeds
                    // the step and the new quotient bit enters at the LSB.
                    quo_d = {quo_q[XLEN-2:0], step_q};
                    rem_d = step_rem;
                    if (cnt_q == 5'd0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_FIX: begin
                    if (is_special(op_q, a_q, b_q)) begin
                        result_d = special_value(op_q, a_q, b_q);
                    end else if (op_is_rem(op_q)) begin
                        result_d = r_neg_q ? -rem_q : rem_q;
                    end else begin
                        result_d = q_neg_q ? -quo_q : quo_q;
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_DIV;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Self-checking bench for div_seq: a vector table plus a short random batch
// run through a result scoreboard, then hand-written sequences for
// back-pressure, flush and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_div_seq;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 35;
`endif
    localparam int NORM_LAT = 35;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic is_spec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3[1:0])
            2'b00: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            2'b01:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Drives a request; returns #1 after the accept edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until out_valid is seen (cycle 1 = the one after accept).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic collect(input string name);
        logic [31:0] e;
        if (out_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            out_ready = 1'b1;
            check({name, " result"}, result, e);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({name, " idle after take"}, {31'b0, busy}, 32'd0);
        end else begin
            n_total++;
            $display("FAIL %s output: out_valid=%0b queued=%0d expected a result", name, out_valid, exp_q.size());
            exp_q.delete();
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int lat;
        check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        exp_q.push_back(exp);
        start_op(f3, a, b);
        wait_valid(lat);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        collect(name);
    endtask

    initial begin
        int          lat;
        int          stable;
        logic        saw_valid;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;

        vecs.push_back('{3'b001, 32'd100,        32'd7,          32'd14,         NORM_LAT});
        vecs.push_back('{3'b011, 32'd100,        32'd7,          32'd2,          NORM_LAT});
        vecs.push_back('{3'b000, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NORM_LAT});
        vecs.push_back('{3'b010, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NORM_LAT});
        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NORM_LAT});
        vecs.push_back('{3'b010, 32'd7,          32'hFFFF_FFFE,  32'd1,          NORM_LAT});
        vecs.push_back('{3'b000, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT});
        vecs.push_back('{3'b011, 32'd5,          32'd0,          32'd5,          SPEC_LAT});
        vecs.push_back('{3'b001, 32'd5,          32'd0,          32'hFFFF_FFFF,  SPEC_LAT});
        vecs.push_back('{3'b010, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  SPEC_LAT});
        vecs.push_back('{3'b000, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  SPEC_LAT});
        vecs.push_back('{3'b010, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          SPEC_LAT});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NORM_LAT});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NORM_LAT});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'd16,         32'd15,         NORM_LAT});
        vecs.push_back('{3'b100, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  NORM_LAT});
        vecs.push_back('{3'b110, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  NORM_LAT});
        vecs.push_back('{3'b000, 32'd0,          32'd5,          32'd0,          NORM_LAT});

        // Reset values
        #3 rst_n = 1'b0;
        #3;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset result", result, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", {31'b0, in_ready}, 32'd1);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Random batch against the behavioral model
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            if (i == 5) b = 32'd0;
            run_op(f3, a, b, model(f3, a, b), is_spec(f3, a, b) ? SPEC_LAT : NORM_LAT,
                   $sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b));
        end

        // Back-pressure: result held 10 cycles with out_ready low
        exp_q.push_back(32'd100);
        start_op(3'b001, 32'd1000, 32'd10);
        wait_valid(lat);
        check("stall latency", 32'(lat), 32'(NORM_LAT));
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && !in_ready && result == 32'd100) stable++;
        end
        check("stall cycles stable", 32'(stable), 32'd10);
        collect("stall");

        // flush overrides an accept in IDLE
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        check("flush blocks in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush blocks accept", {31'b0, busy}, 32'd0);

        // flush at CALC cycle 12
        start_op(3'b001, 32'd1000, 32'd3);
        @(posedge clk);
        #1;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        check("calc12 busy before flush", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush calc busy", {31'b0, busy}, 32'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush calc no out_valid", {31'b0, saw_valid}, 32'd0);
        run_op(3'b001, 32'd9, 32'd3, 32'd3, NORM_LAT, "after flush 9/3");

        // flush in DONE overrides out_ready
        start_op(3'b001, 32'd50, 32'd5);
        wait_valid(lat);
        check("done flush reached done", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        check("done flush out_valid", {31'b0, out_valid}, 32'd0);
        check("done flush busy", {31'b0, busy}, 32'd0);

        // Reset mid-operation
        start_op(3'b011, 32'd77, 32'd5);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midop reset busy", {31'b0, busy}, 32'd0);
        check("midop reset result", result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("midop reset no out_valid", {31'b0, saw_valid}, 32'd0);
        run_op(3'b000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT, "after reset");

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
